// File: rtl/seg_scan_driver.sv
// ----------------------------------------------------------------------------
// seg_scan_driver
//   Time-multiplexed scan of an 8-digit seven-segment display. Each digit owns
//   one slot of REFRESH_DIV cycles. A slot starts with BLANK_CYC cycles in which
//   every anode is off. During that time the upstream digit-code generator
//   settles on the new refcnt. At the end of the blank phase the digit code is
//   sampled once, decoded, and held on the pins until the slot ends.
//
// Ports
//   clk       in   1  system clock, rising edge
//   rst       in   1  synchronous, active-high reset (overrides en)
//   en        in   1  display enable; low = dark, scan held at slot 0
//   dig_code  in   8  digit code for the current refcnt (from upstream)
//   refcnt    out  3  current digit slot, 0 = rightmost
//   an        out  8  anodes, active low, an[i] selects digit i
//   seg       out  7  cathodes, active low, {g,f,e,d,c,b,a}
//   dp        out  1  decimal point, active low, always off
//   bad_code  out  1  sticky: an undefined dig_code was sampled
// ----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000,  // cycles per digit slot, > BLANK_CYC
    parameter int BLANK_CYC   = 16       // dark cycles at slot start, >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] dig_code,
    output logic [2:0] refcnt,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       bad_code
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    localparam logic [PW-1:0] SLOT_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] DRIVE_PCNT = PW'(BLANK_CYC - 1);

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    logic [PW-1:0] pcnt;
    logic [6:0]    dec_seg;
    logic          dec_valid;

    // Code-to-cathode decode. Undefined codes blank the digit and are flagged.
    always_comb begin
        dec_seg   = SEG_OFF;
        dec_valid = 1'b1;
        case (dig_code)
            8'h00:   dec_seg = 7'b1000000;
            8'h01:   dec_seg = 7'b1111001;
            8'h02:   dec_seg = 7'b0100100;
            8'h03:   dec_seg = 7'b0110000;
            8'h04:   dec_seg = 7'b0011001;
            8'h05:   dec_seg = 7'b0010010;
            8'h06:   dec_seg = 7'b0000010;
            8'h07:   dec_seg = 7'b1111000;
            8'h08:   dec_seg = 7'b0000000;
            8'h09:   dec_seg = 7'b0010000;
            8'h0A:   dec_seg = 7'b0010010;  // S
            8'h0B:   dec_seg = 7'b0101111;  // r
            8'h0C:   dec_seg = 7'b1000110;  // C
            8'h0E:   dec_seg = 7'b0000110;  // E
            8'hFE:   dec_seg = 7'b0111111;  // dash
            8'hFF:   dec_seg = 7'b1111111;  // intentional blank
            default: begin
                dec_seg   = 7'b1111111;
                dec_valid = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt     <= '0;
            refcnt   <= 3'd0;
            an       <= AN_OFF;
            seg      <= SEG_OFF;
            bad_code <= 1'b0;
        end else if (!en) begin
            // Disabled: dark and parked at slot 0; bad_code is left alone.
            pcnt   <= '0;
            refcnt <= 3'd0;
            an     <= AN_OFF;
            seg    <= SEG_OFF;
        end else if (pcnt == SLOT_LAST) begin
            // Slot wrap: advance digit and go dark for the blank phase.
            pcnt   <= '0;
            refcnt <= refcnt + 3'd1;
            an     <= AN_OFF;
            seg    <= SEG_OFF;
        end else begin
            pcnt <= pcnt + PW'(1);
            // Drive edge: single sample of dig_code for this slot. It cannot
            // coincide with the wrap because BLANK_CYC < REFRESH_DIV.
            if (pcnt == DRIVE_PCNT) begin
                an  <= ~(8'b0000_0001 << refcnt);
                seg <= dec_seg;
                if (!dec_valid) begin
                    bad_code <= 1'b1;
                end
            end
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg_scan_driver
//   Directed bench for seg_scan_driver with REFRESH_DIV=8, BLANK_CYC=2.
//   The upstream generator is modelled as "SCORE-" text plus two score
//   digits indexed by refcnt, with an optional override of dig_code.
//   Timeline after a reset edge: slot s drives at edge 8s+2 and wraps at
//   edge 8s+8.
// ----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int REFRESH_DIV = 8;
    localparam int BLANK_CYC   = 2;

    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_S    = 7'b0010010;
    localparam logic [6:0] SEG_R    = 7'b0101111;
    localparam logic [6:0] SEG_C    = 7'b1000110;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_BLK  = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [7:0] dig_code;
    logic [2:0] refcnt;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       bad_code;

    logic [7:0] score_lo = 8'h02;
    logic [7:0] score_hi = 8'h04;
    logic       ovr_en   = 1'b0;
    logic [7:0] ovr_val  = 8'h00;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    // Upstream digit-code generator: "SCORE-" + two score digits.
    always_comb begin
        dig_code = 8'hFF;
        if (ovr_en) begin
            dig_code = ovr_val;
        end else begin
            case (refcnt)
                3'd0: dig_code = score_lo;
                3'd1: dig_code = score_hi;
                3'd2: dig_code = 8'hFE;  // -
                3'd3: dig_code = 8'h0E;  // E
                3'd4: dig_code = 8'h0B;  // r
                3'd5: dig_code = 8'h00;  // O
                3'd6: dig_code = 8'h0C;  // C
                3'd7: dig_code = 8'h0A;  // S
                default: dig_code = 8'hFF;
            endcase
        end
    end

    seg_scan_driver #(
        .REFRESH_DIV(REFRESH_DIV),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dig_code (dig_code),
        .refcnt   (refcnt),
        .an       (an),
        .seg      (seg),
        .dp       (dp),
        .bad_code (bad_code)
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                             input logic [2:0] e_ref);
        check({tag, ".an"},     32'(an),     32'(e_an));
        check({tag, ".seg"},    32'(seg),    32'(e_seg));
        check({tag, ".refcnt"}, 32'(refcnt), 32'(e_ref));
    endtask

    initial begin
        int low;

        // ---- Reset ------------------------------------------------------
        rst = 1'b1;
        en  = 1'b1;
        tick(1);
        check_all("reset", 8'hFF, 7'h7F, 3'd0);
        check("reset.dp", 32'(dp), 32'd1);
        check("reset.bad_code", 32'(bad_code), 32'd0);
        rst = 1'b0;

        // ---- Slot 0: blank then drive "2" --------------------------------
        tick(1);                                   // edge 1, pcnt=1
        check_all("s0_blank", 8'hFF, 7'h7F, 3'd0);
        tick(1);                                   // edge 2, drive
        check_all("s0_drive", 8'hFE, SEG_2, 3'd0);

        // ---- Late dig_code change is ignored -----------------------------
        tick(3);                                   // edge 5, pcnt=5
        score_lo = 8'h07;
        tick(2);                                   // edge 7, pcnt=7
        check_all("s0_hold", 8'hFE, SEG_2, 3'd0);
        tick(1);                                   // edge 8, wrap
        check_all("s1_wrap", 8'hFF, 7'h7F, 3'd1);
        tick(2);                                   // edge 10, drive slot 1
        check_all("s1_drive", 8'hFD, SEG_4, 3'd1);

        // ---- Duty: an low for 6 of 8 cycles ------------------------------
        low = 0;
        for (int i = 0; i < REFRESH_DIV; i++) begin
            tick(1);
            if (an != 8'hFF) low++;
        end                                        // edge 18, slot 2 drive
        check("duty_low_cycles", 32'(low), 32'd6);
        check_all("s2_drive", 8'hFB, SEG_DASH, 3'd2);

        // ---- Undefined code in slot 3 ------------------------------------
        ovr_en  = 1'b1;
        ovr_val = 8'h0D;
        tick(8);                                   // edge 26, slot 3 drive
        check_all("s3_bad", 8'hF7, SEG_BLK, 3'd3);
        check("s3_bad.bad_code", 32'(bad_code), 32'd1);
        ovr_en = 1'b0;
        tick(8);                                   // edge 34, slot 4 drive
        check_all("s4_drive", 8'hEF, SEG_R, 3'd4);
        check("s4.bad_code_sticky", 32'(bad_code), 32'd1);
        tick(8);                                   // edge 42, slot 5 drive
        check_all("s5_drive", 8'hDF, SEG_0, 3'd5);

        // ---- Disable mid-slot --------------------------------------------
        tick(2);                                   // edge 44, pcnt=4
        en = 1'b0;
        tick(1);
        check_all("dis", 8'hFF, 7'h7F, 3'd0);
        check("dis.bad_code_held", 32'(bad_code), 32'd1);
        en = 1'b1;
        tick(1);                                   // pcnt 0 -> 1
        check_all("reen_blank", 8'hFF, 7'h7F, 3'd0);
        tick(1);                                   // drive slot 0, new "7"
        check_all("reen_drive", 8'hFE, SEG_7, 3'd0);

        // ---- Reset mid-slot while slot 3 is lit ---------------------------
        tick(8);
        check_all("r_s1", 8'hFD, SEG_4, 3'd1);
        tick(16);
        check_all("r_s3", 8'hF7, SEG_E, 3'd3);
        tick(2);
        rst = 1'b1;
        tick(1);
        check_all("midrst", 8'hFF, 7'h7F, 3'd0);
        check("midrst.bad_code", 32'(bad_code), 32'd0);
        rst = 1'b0;

        // ---- Full scan and refcnt 7 -> 0 wrap ----------------------------
        tick(50);                                  // slot 6 drive
        check_all("s6_drive", 8'hBF, SEG_C, 3'd6);
        tick(8);                                   // slot 7 drive
        check_all("s7_drive", 8'h7F, SEG_S, 3'd7);
        tick(6);                                   // wrap 7 -> 0
        check_all("wrap_blank", 8'hFF, 7'h7F, 3'd0);
        tick(2);
        check_all("wrap_s0", 8'hFE, SEG_7, 3'd0);
        check("final.bad_code", 32'(bad_code), 32'd0);
        check("final.dp", 32'(dp), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
